// File: rtl/mem_sequencer.sv
// mem_sequencer: write/read-back sequencer for a 2**ADDR_W x DATA_W single-port
// memory wrapper. Incoming words are stored at consecutive addresses from 0; a
// rd_start pulse streams them back in order and then empties the buffer.
//
//   state   | meaning
//   --------+-----------------------------------------------------------------
//   S_IDLE  | accepting writes; waits for the write pipe to drain on a read request
//   S_READ  | issuing read addresses 0..count-1, one per cycle
//   S_DRAIN | last address issued; waiting for the final word to leave out_data
module mem_sequencer #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic              rd_start,
   input  logic              clear,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_dout
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] C_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] C_ONE  = (ADDR_W+1)'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t            r_state,     w_state_nxt;
   logic [ADDR_W-1:0] r_wr_ptr,    w_wr_ptr_nxt;
   logic [ADDR_W:0]   r_count,     w_count_nxt;
   logic [ADDR_W-1:0] r_rd_ptr,    w_rd_ptr_nxt;
   logic              r_rd_pend,   w_rd_pend_nxt;
   logic              r_wp,        w_wp_nxt;
   logic [ADDR_W-1:0] r_wp_addr,   w_wp_addr_nxt;
   logic              r_mem_we,    w_mem_we_nxt;
   logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_nxt;
   logic [DATA_W-1:0] r_mem_din,   w_mem_din_nxt;
   logic              r_in_ready,  w_in_ready_nxt;
   // read pipe: stage 0 = address registered, stage 1 = RAM sampling it
   logic              r_rv0,       w_rv0_nxt;
   logic              r_rl0,       w_rl0_nxt;
   logic              r_rv1,       w_rv1_nxt;
   logic              r_rl1,       w_rl1_nxt;
   logic              r_out_valid, w_out_valid_nxt;
   logic              r_out_last,  w_out_last_nxt;
   logic [DATA_W-1:0] r_out_data,  w_out_data_nxt;

   logic              w_accept;
   logic              w_rd_last;

   assign w_accept  = in_valid & r_in_ready;
   assign w_rd_last = ({1'b0, r_rd_ptr} == (r_count - C_ONE));

   // Next-state and next-output logic; clear overrides everything after the case.
   always_comb begin
      w_state_nxt     = r_state;
      w_wr_ptr_nxt    = r_wr_ptr;
      w_count_nxt     = r_count;
      w_rd_ptr_nxt    = r_rd_ptr;
      w_rd_pend_nxt   = r_rd_pend;
      w_wp_nxt        = 1'b0;
      w_wp_addr_nxt   = r_wp_addr;
      w_mem_we_nxt    = 1'b0;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_din_nxt   = r_mem_din;
      w_rv0_nxt       = 1'b0;
      w_rl0_nxt       = 1'b0;
      w_rv1_nxt       = r_rv0;
      w_rl1_nxt       = r_rl0;
      w_out_valid_nxt = r_rv1;
      w_out_last_nxt  = r_rl1;
      w_out_data_nxt  = r_rv1 ? mem_dout : r_out_data;

      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               // data goes out now, address/we follow one cycle later so they
               // line up with the wrapper's internal write-data register
               w_mem_din_nxt = in_data;
               w_wp_nxt      = 1'b1;
               w_wp_addr_nxt = r_wr_ptr;
               w_wr_ptr_nxt  = r_wr_ptr + ADDR_W'(1);
               w_count_nxt   = r_count + C_ONE;
            end
            if (r_wp) begin
               w_mem_we_nxt   = 1'b1;
               w_mem_addr_nxt = r_wp_addr;
            end
            if (rd_start && !r_rd_pend && ((r_count != '0) || w_accept)) begin
               w_rd_pend_nxt = 1'b1;
            end
            // only start reading once no write is staged or being committed
            if (r_rd_pend && !r_wp && !r_mem_we) begin
               w_mem_addr_nxt = '0;
               w_rd_ptr_nxt   = ADDR_W'(1);
               w_rv0_nxt      = 1'b1;
               w_rl0_nxt      = (r_count == C_ONE);
               w_state_nxt    = (r_count == C_ONE) ? S_DRAIN : S_READ;
            end
         end
         S_READ: begin
            w_mem_addr_nxt = r_rd_ptr;
            w_rd_ptr_nxt   = r_rd_ptr + ADDR_W'(1);
            w_rv0_nxt      = 1'b1;
            w_rl0_nxt      = w_rd_last;
            if (w_rd_last) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (r_out_last) begin
               w_count_nxt   = '0;
               w_wr_ptr_nxt  = '0;
               w_rd_pend_nxt = 1'b0;
               w_state_nxt   = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      if (clear) begin
         w_state_nxt     = S_IDLE;
         w_count_nxt     = '0;
         w_wr_ptr_nxt    = '0;
         w_rd_pend_nxt   = 1'b0;
         w_wp_nxt        = 1'b0;
         w_mem_we_nxt    = 1'b0;
         w_rv0_nxt       = 1'b0;
         w_rl0_nxt       = 1'b0;
         w_rv1_nxt       = 1'b0;
         w_rl1_nxt       = 1'b0;
         w_out_valid_nxt = 1'b0;
         w_out_last_nxt  = 1'b0;
      end

      w_in_ready_nxt = (w_state_nxt == S_IDLE) && (w_count_nxt != C_FULL) && !w_rd_pend_nxt;
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_wr_ptr    <= '0;
         r_count     <= '0;
         r_rd_ptr    <= '0;
         r_rd_pend   <= 1'b0;
         r_wp        <= 1'b0;
         r_wp_addr   <= '0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_din   <= '0;
         r_in_ready  <= 1'b0;
         r_rv0       <= 1'b0;
         r_rl0       <= 1'b0;
         r_rv1       <= 1'b0;
         r_rl1       <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_data  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_wr_ptr    <= w_wr_ptr_nxt;
         r_count     <= w_count_nxt;
         r_rd_ptr    <= w_rd_ptr_nxt;
         r_rd_pend   <= w_rd_pend_nxt;
         r_wp        <= w_wp_nxt;
         r_wp_addr   <= w_wp_addr_nxt;
         r_mem_we    <= w_mem_we_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_din   <= w_mem_din_nxt;
         r_in_ready  <= w_in_ready_nxt;
         r_rv0       <= w_rv0_nxt;
         r_rl0       <= w_rl0_nxt;
         r_rv1       <= w_rv1_nxt;
         r_rl1       <= w_rl1_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_out_last  <= w_out_last_nxt;
         r_out_data  <= w_out_data_nxt;
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign full      = (r_count == C_FULL);
   assign empty     = (r_count == '0);
   assign mem_addr  = r_mem_addr;
   assign mem_din   = r_mem_din;
   assign mem_we    = r_mem_we;

endmodule

// File: tb/tb_mem_sequencer.sv
// Testbench for mem_sequencer with a behavioural model of the 16x4 memory wrapper
// (write-data register + one-cycle read latency). Write and read-back
// expectations are queued when stimulus is driven and compared as the DUT emits.
module tb_mem_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [3:0] in_data = '0;
   logic       in_ready;
   logic       rd_start = 1'b0;
   logic       clear = 1'b0;
   logic       out_valid;
   logic [3:0] out_data;
   logic       out_last;
   logic       full;
   logic       empty;
   logic [3:0] mem_addr;
   logic [3:0] mem_din;
   logic       mem_we;
   logic [3:0] mem_dout;

   mem_sequencer #(.ADDR_W(4), .DATA_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .rd_start(rd_start), .clear(clear),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
      .full(full), .empty(empty),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;

   // memory wrapper model
   logic [3:0] ram [16];
   logic [3:0] din_q = '0;
   logic [3:0] dout_r = '0;
   initial for (int i = 0; i < 16; i++) ram[i] = 4'(i) ^ 4'hA;
   always @(posedge clk) begin
      din_q <= mem_din;
      if (mem_we) ram[mem_addr] <= din_q;
      dout_r <= ram[mem_addr];
   end
   assign mem_dout = dout_r;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_err = 0;
   int n_out = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct { logic [3:0] addr; logic [3:0] data; int cyc; } wr_t;
   typedef struct { logic [3:0] data; logic last; int cyc; } rd_t;
   wr_t wq[$];
   rd_t rq[$];
   logic [3:0] exp_wptr = '0;
   logic [3:0] prev_din = '0;

   // scoreboard monitor: records accepts, checks memory writes and output words
   always @(negedge clk) begin
      wr_t w;
      rd_t r;
      if (rst_n && in_valid && in_ready && !clear) begin
         wq.push_back('{exp_wptr, in_data, cyc});
         exp_wptr = exp_wptr + 4'd1;
      end
      if (mem_we) begin
         if (wq.size() == 0) check("unexpected_mem_we", {31'd0, mem_we}, 32'd0);
         else begin
            w = wq.pop_front();
            check("wr_addr", {28'd0, mem_addr}, {28'd0, w.addr});
            check("wr_din_lead", {28'd0, prev_din}, {28'd0, w.data});
            check("wr_latency", cyc, w.cyc + 2);
         end
      end
      prev_din = mem_din;
      if (out_valid) begin
         n_out++;
         if (rq.size() == 0) check("unexpected_out", {31'd0, out_valid}, 32'd0);
         else begin
            r = rq.pop_front();
            check("out_data", {28'd0, out_data}, {28'd0, r.data});
            check("out_last", {31'd0, out_last}, {31'd0, r.last});
            check("out_cycle", cyc, r.cyc);
         end
      end
   end

   task automatic write_seq(input int n, input logic [63:0] words);
      int t;
      for (int i = 0; i < n; i++) begin
         in_data  = words[4*i +: 4];
         in_valid = 1'b1;
         t = 0;
         while (!in_ready) begin
            @(posedge clk); #1;
            t++;
            if (t > 50) begin
               check("ready_timeout", {31'd0, in_ready}, 32'd1);
               break;
            end
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   // lat: cycles from the rd_start drive cycle to the first output word
   task automatic do_read(input int n, input logic [63:0] words, input int lat);
      int c;
      c = cyc;
      for (int i = 0; i < n; i++) rq.push_back('{words[4*i +: 4], (i == n - 1), c + lat + i});
      rd_start = 1'b1;
      @(posedge clk); #1;
      rd_start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int t;
      t = 0;
      while ((rq.size() != 0 || out_valid) && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      check({name, "_drain"}, rq.size(), 0);
      check({name, "_ready_after"}, {31'd0, in_ready}, 32'd1);
      check({name, "_empty_after"}, {31'd0, empty}, 32'd1);
      exp_wptr = '0;
   endtask

   typedef struct { int n; logic [63:0] words; logic exp_full; } vec_t;
   vec_t vecs[4];

   initial begin
      int n0;
      int t;
      vecs[0] = '{3,  64'h5A3, 1'b0};
      vecs[1] = '{16, 64'hFEDCBA9876543210, 1'b1};
      vecs[2] = '{1,  64'hC, 1'b0};
      vecs[3] = '{5,  64'h0F69E, 1'b0};

      #3;
      check("reset_outputs",
            {26'd0, in_ready, out_valid, out_last, mem_we, full, empty},
            {26'd0, 6'b000001});
      check("reset_buses", {20'd0, mem_addr, mem_din, out_data}, 32'd0);
      #9 rst_n = 1'b1;
      @(posedge clk); #1;
      check("ready_after_reset", {31'd0, in_ready}, 32'd1);
      check("empty_after_reset", {31'd0, empty}, 32'd1);

      for (int v = 0; v < 4; v++) begin
         write_seq(vecs[v].n, vecs[v].words);
         check("full_after_writes", {31'd0, full}, {31'd0, vecs[v].exp_full});
         check("ready_after_writes", {31'd0, in_ready}, {31'd0, !vecs[v].exp_full});
         check("empty_after_writes", {31'd0, empty}, 32'd0);
         if (vecs[v].exp_full) begin
            in_data  = 4'h7;
            in_valid = 1'b1;
            repeat (3) @(posedge clk);
            #1 in_valid = 1'b0;
            check("full_hold", {31'd0, full}, 32'd1);
         end
         repeat (2) @(posedge clk);
         #1;
         n0 = n_out;
         do_read(vecs[v].n, vecs[v].words, 4);
         wait_done("table");
         check("table_out_count", n_out - n0, vecs[v].n);
      end

      // read request on an empty buffer
      n0 = n_out;
      rd_start = 1'b1;
      @(posedge clk); #1;
      rd_start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("empty_rd_ready", {31'd0, in_ready}, 32'd1);
      end
      check("empty_rd_no_out", n_out, n0);

      // read requested the cycle after the last accept, write still in flight
      write_seq(2, 64'hB4);
      n0 = n_out;
      do_read(2, 64'hB4, 5);
      wait_done("inflight");
      check("inflight_out_count", n_out - n0, 2);

      // clear during read-back
      write_seq(8, 64'h87654321);
      repeat (2) @(posedge clk);
      #1;
      n0 = n_out;
      do_read(8, 64'h87654321, 4);
      t = 0;
      while (n_out < n0 + 3 && t < 100) begin
         @(negedge clk); #1;
         t++;
      end
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      rq.delete();
      exp_wptr = '0;
      check("clear_out_valid", {31'd0, out_valid}, 32'd0);
      check("clear_out_last", {31'd0, out_last}, 32'd0);
      check("clear_empty", {31'd0, empty}, 32'd1);
      check("clear_ready", {31'd0, in_ready}, 32'd1);
      repeat (4) @(posedge clk);
      #1;
      check("clear_out_count", n_out - n0, 3);
      write_seq(1, 64'h9);
      repeat (2) @(posedge clk);
      #1;
      n0 = n_out;
      do_read(1, 64'h9, 4);
      wait_done("after_clear");
      check("after_clear_count", n_out - n0, 1);

      // asynchronous reset during read-back
      write_seq(4, 64'hD3E6);
      repeat (2) @(posedge clk);
      #1;
      n0 = n_out;
      do_read(4, 64'hD3E6, 4);
      t = 0;
      while (n_out < n0 + 2 && t < 100) begin
         @(negedge clk); #1;
         t++;
      end
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("midread_reset_outputs",
            {26'd0, in_ready, out_valid, out_last, mem_we, full, empty},
            {26'd0, 6'b000001});
      check("midread_reset_buses", {20'd0, mem_addr, mem_din, out_data}, 32'd0);
      rq.delete();
      wq.delete();
      exp_wptr = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_reset_ready", {31'd0, in_ready}, 32'd1);
      check("post_reset_empty", {31'd0, empty}, 32'd1);
      repeat (5) @(posedge clk);
      #1;
      check("post_reset_silent", {31'd0, out_valid}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_sequencer.md
# mem_sequencer

Write/read-back sequencer that sits directly upstream of the 16x4 single-port memory wrapper and drives its address, write-data and write-enable inputs. It accepts a valid/ready stream of 4-bit words and stores them at consecutive addresses from 0. On request, it reads the stored words back in order as a valid/last output stream, then empties the buffer. It owns all timing alignment between the stream interfaces and the memory port, including the wrapper's one-stage write-data register and the RAM's one-cycle read latency.

## Interface
- ADDR_W, 4, memory address width; depth = 2**ADDR_W = 16
- DATA_W, 4, word width
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  write word offered
- in_data  in  DATA_W  write word
- in_ready  out  1  registered; word accepted on an edge where in_valid & in_ready
- rd_start  in  1  one-cycle pulse requesting a read-back of all stored words
- clear  in  1  synchronous flush of the buffer
- out_valid  out  1  registered; read-back word valid (no backpressure)
- out_data  out  DATA_W  registered read-back word
- out_last  out  1  high together with the final out_valid word
- full  out  1  count == 16
- empty  out  1  count == 0
- mem_addr  out  ADDR_W  to memory addra
- mem_din  out  DATA_W  to memory din (registered once more inside the wrapper)
- mem_we  out  1  to memory wea
- mem_dout  in  DATA_W  from memory douta; valid one cycle after the address is sampled

## Operation
- State machine: IDLE, READ, DRAIN.
- Registers:
  - wr_ptr: ADDR_W bits.
  - count: ADDR_W+1 bits, range 0..16.
  - rd_ptr: ADDR_W bits.
  - rd_pend: 1 bit.
  - Write pipeline flag wp: 1 bit.
- IDLE, write accepted at edge k:
  - mem_din <= in_data at edge k.
  - At edge k+1, mem_we <= 1 and mem_addr <= the slot index (wr_ptr at k).
  - The RAM commits at edge k+2.
  - wr_ptr and count increment at edge k.
- Back-to-back accepts are fully pipelined, one word per cycle.
- mem_we is 0 in every cycle that has no write in flight.
- in_ready = IDLE & ~full_next & ~rd_pend, computed from next-state values. Writing the 16th word drops in_ready on the same edge.
- Writes into a full buffer are impossible; in_valid is ignored while in_ready = 0.
- rd_start in IDLE:
  - With count == 0, the request is ignored, with no output.
  - Otherwise rd_pend <= 1 and in_ready drops.
- READ is entered at the first edge where rd_pend = 1 and no write is in flight (wp = 0 and mem_we = 0). On entry, rd_ptr is 0.
- READ:
  - Each cycle mem_addr <= rd_ptr and rd_ptr increments.
  - After address count-1 has been issued, go to DRAIN.
- Output path: out_data <= mem_dout and out_valid <= 1, two edges after the corresponding mem_addr is registered.
- DRAIN: waits until the last word has been output, then:
  - count, wr_ptr, rd_pend <= 0.
  - Go to IDLE.
- rd_start outside IDLE, or while rd_pend = 1, is ignored.
- clear (priority over everything except rst_n), at the next edge:
  - state <= IDLE; count, wr_ptr, rd_pend, wp, mem_we, out_valid, out_last <= 0.
  - An in-flight write is dropped.
  - An active read-back is truncated: out_valid drops after that edge and no out_last is generated.
- rst_n low, asynchronously and immediately:
  - State IDLE; all counters 0.
  - in_ready, out_valid, out_last, mem_we, full = 0; mem_addr, mem_din, out_data = 0; empty = 1.
- Reset mid-write discards the word. Reset mid-read discards the remaining output.

## Timing
- After reset release, in_ready = 1 from the first rising edge.
- Write latency: accept edge k → RAM write at edge k+2.
- Read latency: rd_start registered at edge r with an idle write pipeline:
  - READ is entered at r+1 and addresses 0..N-1 are issued at edges r+1..r+N.
  - out_valid is high on cycles following edges r+3..r+N+2.
  - out_last is high with word N-1.
  - in_ready returns 1 on the cycle after out_last.
- rd_start on the same edge as the final in-flight accepted write: READ starts once that write's mem_we cycle has completed. No stale read is possible.
- Output stream is gap-free, N consecutive cycles.

## Test plan
- Reset, then write 3, A, 5 on consecutive cycles → mem_we high 3 cycles at addr 0,1,2 (one cycle after each accept, mem_din leading by one cycle). Then rd_start → out_data 3, A, 5 on 3 consecutive cycles, out_last with 5; empty = 1 afterwards.
- Write 16 words 0..F → full = 1 and in_ready = 0 after the 16th accept. The 17th in_valid (data 7) is ignored. Read-back yields 0..F with out_last on F.
- rd_start with empty = 1 → no out_valid for 10 cycles; in_ready stays 1.
- Write 2 words, assert rd_start on the cycle after the last accept → read starts only after that write's mem_we cycle. Output is the 2 written words, not stale data.
- Write 8 words, start read, assert clear after 3 outputs → out_valid drops, no out_last; count = 0. A new single write of 9 then reads back as 9.
- Pulse rst_n low mid-read → all outputs zero immediately. After release: in_ready = 1, empty = 1.
